// File: rtl/alu_writeback.sv
// Result-retirement buffer between the ALU and a single-write-port register file.
// Queues paired (Y1, Y2) results and drains them one word per granted cycle.
module alu_writeback #(
    parameter int DEPTH = 4,
    parameter int REGW  = 5,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_y1,
    input  logic [31:0]     in_y2,
    input  logic [REGW-1:0] in_dest1,
    input  logic [REGW-1:0] in_dest2,
    input  logic [1:0]      in_mask,
    output logic            wr_en,
    output logic [REGW-1:0] wr_addr,
    output logic [31:0]     wr_data,
    input  logic            wr_grant,
    output logic [CW-1:0]   count,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR1  = 2'd1;
    localparam logic [1:0] S_WR2  = 2'd2;

    logic [31:0]     y1_mem_q    [DEPTH];
    logic [31:0]     y2_mem_q    [DEPTH];
    logic [REGW-1:0] dest1_mem_q [DEPTH];
    logic [REGW-1:0] dest2_mem_q [DEPTH];
    logic [1:0]      mask_mem_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;

    logic          full;
    logic          push;
    logic          push_store;
    logic          pop;
    logic [1:0]    head_mask;
    logic [AW-1:0] rd_ptr_inc;
    logic          next_valid;
    logic [1:0]    next_mask;

    function automatic logic [1:0] first_state(input logic [1:0] mask);
        return mask[0] ? S_WR1 : S_WR2;
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign push_store = push && (in_mask != 2'b00);
    assign head_mask  = mask_mem_q[rd_ptr_q];
    assign rd_ptr_inc = rd_ptr_q + AW'(1);

    assign pop = wr_grant && (((state_q == S_WR1) && !head_mask[1]) || (state_q == S_WR2));

    // After a pop the new head is either already stored or is the entry arriving this cycle.
    assign next_valid = (count_q > CW'(1)) || push_store;
    assign next_mask  = (count_q > CW'(1)) ? mask_mem_q[rd_ptr_inc] : in_mask;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push_store) begin
                    state_d = first_state(in_mask);
                end
            end
            S_WR1: begin
                if (wr_grant) begin
                    if (head_mask[1]) begin
                        state_d = S_WR2;
                    end else begin
                        state_d = next_valid ? first_state(next_mask) : S_IDLE;
                    end
                end
            end
            S_WR2: begin
                if (wr_grant) begin
                    state_d = next_valid ? first_state(next_mask) : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push_store ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_inc : rd_ptr_q;
        count_d  = count_q;
        if (push_store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_store) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_store) begin
            y1_mem_q[wr_ptr_q]    <= in_y1;
            y2_mem_q[wr_ptr_q]    <= in_y2;
            dest1_mem_q[wr_ptr_q] <= in_dest1;
            dest2_mem_q[wr_ptr_q] <= in_dest2;
            mask_mem_q[wr_ptr_q]  <= in_mask;
        end
    end

    assign wr_en   = (state_q != S_IDLE);
    assign wr_addr = (state_q == S_WR2) ? dest2_mem_q[rd_ptr_q] : dest1_mem_q[rd_ptr_q];
    assign wr_data = (state_q == S_WR2) ? y2_mem_q[rd_ptr_q] : y1_mem_q[rd_ptr_q];
    assign count   = count_q;
    assign busy    = (count_q != '0);

endmodule
